// File: rtl/cpu_control_seq.sv
// Hardwired fetch/decode/execute sequencer that drives the CPU control_bus.
// State and the control_bus register change on the falling clock edge so the
// datapath sees stable controls at its rising edge.
module cpu_control_seq #(
  parameter int BUS_W   = 33,
  parameter int PC_AMID = 0,
  parameter int MEM_MID = 4,
  parameter int IR0_SID = 0,
  parameter int IR1_SID = 1,
  parameter int ALU_MID = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [15:0]      instr,
  output logic [BUS_W-1:0] control_bus,
  output logic [3:0]       t_state,
  output logic             halted
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_E0, S_E1, S_E2, S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  alu_q, alu_d, mid_q, mid_d, sid_q, sid_d;
  logic [1:0]  amid_q, amid_d;
  logic        pc_inr_q, pc_inr_d, mid_en_q, mid_en_d;
  logic        sid_en_q, sid_en_d, amid_en_q, amid_en_d;
  logic        halted_d;
  // Latched instruction fields: class, ir1[4:0], ir0[4:0]
  logic [1:0]  cls_q, cls_d;
  logic [4:0]  hi_q, hi_d, lo_q, lo_d;
  logic        enter_t0;
  logic        instr_unused;

  assign instr_unused = ^{instr[15:13], instr[5]};

  // State, latched instruction and control_bus fields; negedge, async clear
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      alu_q     <= '0;
      mid_q     <= '0;
      sid_q     <= '0;
      amid_q    <= '0;
      pc_inr_q  <= 1'b0;
      mid_en_q  <= 1'b0;
      sid_en_q  <= 1'b0;
      amid_en_q <= 1'b0;
      halted    <= 1'b0;
      cls_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      alu_q     <= alu_d;
      mid_q     <= mid_d;
      sid_q     <= sid_d;
      amid_q    <= amid_d;
      pc_inr_q  <= pc_inr_d;
      mid_en_q  <= mid_en_d;
      sid_en_q  <= sid_en_d;
      amid_en_q <= amid_en_d;
      halted    <= halted_d;
      cls_q     <= cls_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Next state and next control fields; unlisted fields hold their value
  always_comb begin
    state_d   = state_q;
    alu_d     = alu_q;
    mid_d     = mid_q;
    sid_d     = sid_q;
    amid_d    = amid_q;
    pc_inr_d  = pc_inr_q;
    mid_en_d  = mid_en_q;
    sid_en_d  = sid_en_q;
    amid_en_d = amid_en_q;
    halted_d  = halted;
    cls_d     = cls_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    enter_t0  = 1'b0;

    if (!(stall && state_q != S_HALT)) begin
      unique case (state_q)
        S_IDLE: enter_t0 = 1'b1;
        S_T0: begin
          state_d  = S_T1;
          sid_d    = 5'(IR0_SID);
          sid_en_d = 1'b1;
          pc_inr_d = 1'b1;
        end
        S_T1: begin
          state_d  = S_T2;
          sid_en_d = 1'b0;
          pc_inr_d = 1'b0;
        end
        S_T2: begin
          state_d  = S_T3;
          sid_d    = 5'(IR1_SID);
          sid_en_d = 1'b1;
          pc_inr_d = 1'b1;
        end
        S_T3: begin
          state_d   = S_T4;
          pc_inr_d  = 1'b0;
          mid_en_d  = 1'b0;
          sid_en_d  = 1'b0;
          amid_en_d = 1'b0;
        end
        S_T4: begin
          // Decode straight from instr on the same edge that latches it
          cls_d = instr[7:6];
          hi_d  = instr[12:8];
          lo_d  = instr[4:0];
          unique case (instr[7:6])
            2'b11: begin
              state_d   = S_HALT;
              halted_d  = 1'b1;
              alu_d     = '0;
              mid_d     = '0;
              sid_d     = '0;
              amid_d    = '0;
            end
            2'b10: state_d = S_E0;
            2'b01: begin
              state_d  = S_E0;
              alu_d    = instr[4:0];
              mid_d    = 5'(ALU_MID);
              mid_en_d = 1'b1;
            end
            default: begin
              state_d  = S_E0;
              alu_d    = '0;
              mid_d    = instr[12:8];
              mid_en_d = 1'b1;
            end
          endcase
        end
        S_E0: begin
          if (cls_q == 2'b10) begin
            enter_t0 = 1'b1;
          end else begin
            state_d  = S_E1;
            sid_d    = (cls_q == 2'b01) ? hi_q : lo_q;
            sid_en_d = 1'b1;
          end
        end
        S_E1: begin
          state_d  = S_E2;
          mid_en_d = 1'b0;
          sid_en_d = 1'b0;
          alu_d    = '0;
        end
        S_E2:   enter_t0 = 1'b1;
        S_HALT: state_d  = S_HALT;
        default: state_d = S_IDLE;
      endcase

      if (enter_t0) begin
        state_d   = S_T0;
        amid_d    = 2'(PC_AMID);
        amid_en_d = 1'b1;
        mid_d     = 5'(MEM_MID);
        mid_en_d  = 1'b1;
      end
    end
  end

  assign t_state     = state_q;
  assign control_bus = {{(BUS_W-21){1'b0}}, alu_q, mid_q, sid_q, amid_q,
                        pc_inr_q, mid_en_q, sid_en_q, amid_en_q};

endmodule
